// File: rtl/memstage.sv
// -----------------------------------------------------------------------------
// memstage -- MEM-stage data-memory access unit of the pipelined LEGv8 core.
//
// Takes the EX/MEM register outputs and performs at most one load or store per
// instruction over a variable-latency req/ack data-memory port. While the
// access is outstanding, stall freezes PC, IF/ID, ID/EX and EX/MEM. Load data
// is aligned to bit 0 and sign- or zero-extended before MEM/WB captures it.
//
// Parameters
//   WORDSIZE     datapath width, must be 64 (8 byte lanes)
//   REGADDRSIZE  destination register address width
//   TIMEOUT      cycles spent in REQ before the access is aborted (1..255)
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   i_nopin       EX/MEM bubble flag; the instruction is void
//   i_memread     load requested
//   i_memwrite    store requested (wins when both are set)
//   i_size        00=byte 01=half 10=word 11=dword
//   i_signext     sign-extend load result
//   i_addr        effective address
//   i_wdata       store data
//   i_rdin        destination register, passed straight to o_rdout
//   o_dreq        memory request, held until ack or timeout
//   o_dwe         1=write 0=read, valid with o_dreq
//   o_daddr       doubleword-aligned address
//   o_dwdata      store data shifted onto its byte lanes
//   o_dbe         byte enables
//   i_dack        memory completion pulse
//   i_drdata      read data, valid with i_dack
//   o_stall       freeze upstream pipeline (combinational)
//   o_loaddata    extracted load result, valid in DONE
//   o_fault       access aborted (timeout or misaligned), valid in DONE
//   o_rdout       i_rdin, combinational
//
// Build option
//   MEMSTAGE_ALIGNCHECK_EN  when defined, a half/word/dword access whose
//                           address is not a multiple of its size issues no
//                           request and completes with a fault after a single
//                           stall cycle. When undefined, misaligned accesses
//                           proceed with byte enables truncated at lane 7.
// -----------------------------------------------------------------------------
module memstage #(
  parameter int WORDSIZE    = 64,
  parameter int REGADDRSIZE = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_nopin,
  input  logic                   i_memread,
  input  logic                   i_memwrite,
  input  logic [1:0]             i_size,
  input  logic                   i_signext,
  input  logic [WORDSIZE-1:0]    i_addr,
  input  logic [WORDSIZE-1:0]    i_wdata,
  input  logic [REGADDRSIZE-1:0] i_rdin,
  output logic                   o_dreq,
  output logic                   o_dwe,
  output logic [WORDSIZE-1:0]    o_daddr,
  output logic [WORDSIZE-1:0]    o_dwdata,
  output logic [7:0]             o_dbe,
  input  logic                   i_dack,
  input  logic [WORDSIZE-1:0]    i_drdata,
  output logic                   o_stall,
  output logic [WORDSIZE-1:0]    o_loaddata,
  output logic                   o_fault,
  output logic [REGADDRSIZE-1:0] o_rdout
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic                 r_dreq;
  logic                 r_dwe;
  logic [WORDSIZE-1:0]  r_daddr;
  logic [WORDSIZE-1:0]  r_dwdata;
  logic [7:0]           r_dbe;
  logic [WORDSIZE-1:0]  r_loaddata;
  logic                 r_fault;
  logic [7:0]           r_count;
  logic [1:0]           r_size;
  logic                 r_signext;
  logic [2:0]           r_lane;

  state_t               w_state_next;
  logic                 w_dreq_next;
  logic                 w_dwe_next;
  logic [WORDSIZE-1:0]  w_daddr_next;
  logic [WORDSIZE-1:0]  w_dwdata_next;
  logic [7:0]           w_dbe_next;
  logic [WORDSIZE-1:0]  w_loaddata_next;
  logic                 w_fault_next;
  logic [7:0]           w_count_next;
  logic [1:0]           w_size_next;
  logic                 w_signext_next;
  logic [2:0]           w_lane_next;

  // ---------------------------------------------------------------------------
  // Request decode and byte-lane steering from the EX/MEM inputs
  // ---------------------------------------------------------------------------
  logic                 w_op;
  logic [2:0]           w_lane_in;
  logic [7:0]           w_size_mask;
  logic [15:0]          w_be_wide;
  logic [7:0]           w_be_in;
  logic [WORDSIZE-1:0]  w_wdata_lane;
  logic                 w_misaligned;

  // A bubble never touches memory; a read+write combination is a store.
  assign w_op      = (i_memread | i_memwrite) & ~i_nopin;
  assign w_lane_in = i_addr[2:0];

  always_comb begin
    w_size_mask = 8'h01;
    case (i_size)
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  // Shift into a 16-bit field so that lanes past 7 fall off the top instead of
  // wrapping around; only the low byte is used.
  assign w_be_wide    = {8'h00, w_size_mask} << w_lane_in;
  assign w_be_in      = w_be_wide[7:0];
  assign w_wdata_lane = i_wdata << {w_lane_in, 3'b000};

`ifdef MEMSTAGE_ALIGNCHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (i_size)
      2'b01:   w_misaligned = w_lane_in[0];
      2'b10:   w_misaligned = |w_lane_in[1:0];
      2'b11:   w_misaligned = |w_lane_in;
      default: w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load extraction: bring the addressed lane down to bit 0, then keep only the
  // access size and extend. Uses the lane/size latched at request time so the
  // upstream registers may change freely while memory answers.
  // ---------------------------------------------------------------------------
  logic [WORDSIZE-1:0]  w_rd_shifted;
  logic [WORDSIZE-1:0]  w_load_ext;

  assign w_rd_shifted = i_drdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_ext = w_rd_shifted;
    case (r_size)
      2'b00: w_load_ext = {{(WORDSIZE-8){r_signext & w_rd_shifted[7]}},
                           w_rd_shifted[7:0]};
      2'b01: w_load_ext = {{(WORDSIZE-16){r_signext & w_rd_shifted[15]}},
                           w_rd_shifted[15:0]};
      2'b10: w_load_ext = {{(WORDSIZE-32){r_signext & w_rd_shifted[31]}},
                           w_rd_shifted[31:0]};
      default: w_load_ext = w_rd_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_dreq_next     = r_dreq;
    w_dwe_next      = r_dwe;
    w_daddr_next    = r_daddr;
    w_dwdata_next   = r_dwdata;
    w_dbe_next      = r_dbe;
    w_loaddata_next = r_loaddata;
    w_fault_next    = r_fault;
    w_count_next    = r_count;
    w_size_next     = r_size;
    w_signext_next  = r_signext;
    w_lane_next     = r_lane;

    case (r_state)
      ST_IDLE: begin
        if (w_op) begin
          w_dwe_next     = i_memwrite;
          w_daddr_next   = {i_addr[WORDSIZE-1:3], 3'b000};
          w_dwdata_next  = w_wdata_lane;
          w_dbe_next     = w_be_in;
          w_size_next    = i_size;
          w_signext_next = i_signext;
          w_lane_next    = w_lane_in;
          w_count_next   = 8'd0;
          if (w_misaligned) begin
            // Rejected before reaching the bus: report in DONE next cycle.
            w_dreq_next     = 1'b0;
            w_loaddata_next = '0;
            w_fault_next    = 1'b1;
            w_state_next    = ST_DONE;
          end else begin
            w_dreq_next  = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // Ack wins over timeout when both land on the final allowed cycle.
        if (i_dack) begin
          w_dreq_next = 1'b0;
          if (!r_dwe) begin
            w_loaddata_next = w_load_ext;
          end
          w_state_next = ST_DONE;
        end else if (r_count == TIMEOUT_LAST) begin
          w_dreq_next     = 1'b0;
          w_loaddata_next = '0;
          w_fault_next    = 1'b1;
          w_state_next    = ST_DONE;
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end

      ST_DONE: begin
        // MEM/WB captures loaddata/fault on this edge; the fault flag must not
        // leak into the next instruction.
        w_fault_next = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
        w_dreq_next  = 1'b0;
        w_fault_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dreq     <= 1'b0;
      r_dwe      <= 1'b0;
      r_daddr    <= '0;
      r_dwdata   <= '0;
      r_dbe      <= 8'h00;
      r_loaddata <= '0;
      r_fault    <= 1'b0;
      r_count    <= 8'd0;
      r_size     <= 2'b00;
      r_signext  <= 1'b0;
      r_lane     <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_dreq     <= w_dreq_next;
      r_dwe      <= w_dwe_next;
      r_daddr    <= w_daddr_next;
      r_dwdata   <= w_dwdata_next;
      r_dbe      <= w_dbe_next;
      r_loaddata <= w_loaddata_next;
      r_fault    <= w_fault_next;
      r_count    <= w_count_next;
      r_size     <= w_size_next;
      r_signext  <= w_signext_next;
      r_lane     <= w_lane_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stall rises in the same cycle the instruction arrives so EX/MEM holds it
  // while the request is being issued. It is forced low during reset so the
  // pipeline is not frozen by a stage that is being cleared.
  assign o_stall = rst_n & (((r_state == ST_IDLE) & w_op) | (r_state == ST_REQ));

  assign o_dreq     = r_dreq;
  assign o_dwe      = r_dwe;
  assign o_daddr    = r_daddr;
  assign o_dwdata   = r_dwdata;
  assign o_dbe      = r_dbe;
  assign o_loaddata = r_loaddata;
  assign o_fault    = r_fault;
  assign o_rdout    = i_rdin;

endmodule
